hsi_tx_arb: RTL
===============

HSI_TX_ARB -- requirements
Module: hsi_tx_arb

Interface
REQ-001 Parameter GUARD_CYC, default 2: idle clk cycles forced between two granted frames, range 0..15.
REQ-002 Parameter TMO_CYC, default 255: XFER cycles allowed without a ser_d_sending rising edge before abort, range 1..255.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 src_tx_rdy  input  3  per-source frame-pending flag; bit0 CCW, bit1 status word, bit2 data word.
REQ-006 src_tx_en  output  3  one-cycle start pulse to the granted source.
REQ-007 src_d0, src_d1, src_d2  input  8 each  source byte buses.
REQ-008 src_d_rdy  input  3  per-source byte-valid flag.
REQ-009 src_d_sending  output  3  serializer busy flag, routed to the granted source only.
REQ-010 ser_d  output  8  byte to serializer.
REQ-011 ser_d_rdy  output  1  byte-valid to serializer.
REQ-012 ser_d_sending  input  1  serializer shifting a byte.
REQ-013 grant_id  output  2  index of current/last grant; 3 = none since reset.
REQ-014 busy  output  1  high in GRANT, XFER or GUARD.
REQ-015 tmo_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-016 FSM states: IDLE, GRANT, XFER, GUARD; 2-bit encoding; unused codes return to IDLE next cycle.
REQ-017 IDLE: if any src_tx_rdy bit is high, select winner, load grant_id, go to GRANT; else stay.
REQ-018 Arbitration: round-robin; search starts at (last grant + 1) mod 3; after reset search starts at bit0.
REQ-019 Simultaneous requests: only the single winner per REQ-018 is granted; losers keep waiting with no pulse.
REQ-020 GRANT: lasts exactly one cycle; src_tx_en[grant_id] = 1, other bits 0; next state XFER.
REQ-021 XFER: ser_d = selected src_d, ser_d_rdy = selected src_d_rdy; src_d_sending[grant_id] = ser_d_sending; other src_d_sending bits 0.
REQ-022 Outside XFER: ser_d = 0, ser_d_rdy = 0, all src_d_sending = 0.
REQ-023 XFER exit: when src_tx_rdy[grant_id] = 0 and ser_d_sending = 0 in the same cycle, go to GUARD (GUARD_CYC>0) or IDLE (GUARD_CYC=0).
REQ-024 Timeout counter, 8 bits: cleared on entry to XFER and on each ser_d_sending rising edge (0->1, registered previous value); incremented otherwise in XFER, saturates.
REQ-025 Counter reaching TMO_CYC: pulse tmo_err for one cycle, leave XFER per REQ-023 targets regardless of src_tx_rdy.
REQ-026 Exit and timeout coincide: normal exit wins, no tmo_err.
REQ-027 GUARD: 4-bit counter loaded with GUARD_CYC-1 on entry, decrements each cycle, go to IDLE on 0; requests ignored.
REQ-028 Requests raised in XFER/GUARD are held by the sources and served from IDLE; no request is latched internally.
REQ-029 Winner dropping src_tx_rdy during GRANT: still enters XFER; exits next cycle if ser_d_sending = 0.
REQ-030 grant_id keeps its value after the frame until the next grant.
REQ-031 busy is a registered decode of state, not of inputs.

Reset
REQ-032 On n_rst low, asynchronously: state IDLE, grant_id = 3, round-robin pointer = 2, both counters 0, ser_d_sending history 0.
REQ-033 During reset and first cycle after: src_tx_en = 0, src_d_sending = 0, ser_d = 0, ser_d_rdy = 0, busy = 0, tmo_err = 0.
REQ-034 Reset asserted mid-XFER: all outputs reach the REQ-033 values without a clock edge; the interrupted frame is not resumed.

Verification
REQ-035 Single CCW frame: src_tx_rdy = 001, byte stream 0x05,0x00..0x04 -> tx_en pulse on bit0 one cycle after request, six bytes on ser_d in order, busy drops GUARD_CYC+1 cycles after src_tx_rdy falls.
REQ-036 All three request together, each held for one frame -> grants in order 0,1,2; repeat with all held -> order 0,1,2,0.
REQ-037 Timeout: grant source 1, ser_d_sending held 0 -> tmo_err one-cycle pulse after TMO_CYC XFER cycles, then GUARD, then IDLE.
REQ-038 Exit on the same cycle the counter hits TMO_CYC -> no tmo_err, normal GUARD entry.
REQ-039 n_rst pulsed low mid-XFER with source 2 granted -> outputs per REQ-033 immediately, grant_id = 3, next request from bit0 granted first.
REQ-040 GUARD_CYC = 0, back-to-back requests from source 0 -> new GRANT on the cycle after XFER exit.

Source files
------------

// File: rtl/hsi_tx_arb.sv
// hsi_tx_arb: round-robin arbiter that hands the shared byte serializer to one
// of three frame sources (CCW, status word, data word) at a time. A granted
// source gets a one-cycle start pulse and then owns the byte path until it
// drops its request while the serializer is idle. A stalled transfer is
// aborted by a timeout. An optional guard gap separates consecutive frames.

module hsi_tx_arb #(
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned TMO_CYC   = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] src_tx_rdy,
  output logic [2:0] src_tx_en,
  input  logic [7:0] src_d0,
  input  logic [7:0] src_d1,
  input  logic [7:0] src_d2,
  input  logic [2:0] src_d_rdy,
  output logic [2:0] src_d_sending,
  output logic [7:0] ser_d,
  output logic       ser_d_rdy,
  input  logic       ser_d_sending,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       tmo_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam bit         HAS_GUARD  = (GUARD_CYC != 0);
  localparam logic [3:0] GUARD_LOAD = HAS_GUARD ? 4'(GUARD_CYC - 1) : 4'd0;
  localparam logic [7:0] TMO_VAL    = 8'(TMO_CYC);
  // Where a finished (or aborted) frame goes next.
  localparam logic [1:0] ST_AFTER   = HAS_GUARD ? ST_GUARD : ST_IDLE;

  // Round-robin pick: search starts one past the last grant, wrapping mod 3.
  // A pointer of 2 (the reset value) therefore starts the search at bit0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    idx   = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  // One-hot decode of a source index; index 3 means no source.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_s;
  logic [1:0] grant_id_r;
  logic [1:0] rr_ptr_r;
  logic [7:0] tmo_cnt_r;
  logic [3:0] guard_cnt_r;
  logic       sending_prev_r;
  logic [2:0] tx_en_r;
  logic       busy_r;
  logic       tmo_err_r;

  logic       any_req_s;
  logic [1:0] winner_s;
  logic       sel_req_s;
  logic       rise_s;
  logic       exit_s;
  logic       tmo_hit_s;

  assign any_req_s = |src_tx_rdy;
  assign winner_s  = rr_pick(src_tx_rdy, rr_ptr_r);
  assign rise_s    = ser_d_sending & ~sending_prev_r;

  // Request flag of the currently granted source (none when grant_id is 3).
  always_comb begin
    sel_req_s = 1'b0;
    case (grant_id_r)
      2'd0:    sel_req_s = src_tx_rdy[0];
      2'd1:    sel_req_s = src_tx_rdy[1];
      2'd2:    sel_req_s = src_tx_rdy[2];
      default: sel_req_s = 1'b0;
    endcase
  end

  // Normal end of frame has priority over a timeout landing on the same cycle.
  assign exit_s    = (state_r == ST_XFER) && !sel_req_s && !ser_d_sending;
  assign tmo_hit_s = (state_r == ST_XFER) && !exit_s && !rise_s &&
                     ((tmo_cnt_r + 8'd1) == TMO_VAL);

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: state_s = ST_XFER;
      ST_XFER: begin
        if (exit_s || tmo_hit_s) begin
          state_s = ST_AFTER;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GUARD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: byte path and busy feedback are connected only in XFER.
  always_comb begin
    ser_d         = 8'd0;
    ser_d_rdy     = 1'b0;
    src_d_sending = 3'b000;
    if (state_r == ST_XFER) begin
      case (grant_id_r)
        2'd0: begin
          ser_d         = src_d0;
          ser_d_rdy     = src_d_rdy[0];
          src_d_sending = {2'b00, ser_d_sending};
        end
        2'd1: begin
          ser_d         = src_d1;
          ser_d_rdy     = src_d_rdy[1];
          src_d_sending = {1'b0, ser_d_sending, 1'b0};
        end
        2'd2: begin
          ser_d         = src_d2;
          ser_d_rdy     = src_d_rdy[2];
          src_d_sending = {ser_d_sending, 2'b00};
        end
        default: begin
          ser_d         = 8'd0;
          ser_d_rdy     = 1'b0;
          src_d_sending = 3'b000;
        end
      endcase
    end else begin
      ser_d         = 8'd0;
      ser_d_rdy     = 1'b0;
      src_d_sending = 3'b000;
    end
  end

  // Grant bookkeeping: winner is latched when leaving IDLE and kept afterwards.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant_id_r <= 2'd3;
      rr_ptr_r   <= 2'd2;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      grant_id_r <= winner_s;
      rr_ptr_r   <= winner_s;
    end else begin
      grant_id_r <= grant_id_r;
      rr_ptr_r   <= rr_ptr_r;
    end
  end

  // Serializer activity history, used to detect its 0->1 edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sending_prev_r <= 1'b0;
    end else begin
      sending_prev_r <= ser_d_sending;
    end
  end

  // Timeout counter: restarts on XFER entry and on every new serializer byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == ST_XFER) begin
      if (rise_s) begin
        tmo_cnt_r <= 8'd0;
      end else if (tmo_cnt_r != 8'hFF) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  // Guard gap counter: loaded on GUARD entry, counts down to the IDLE return.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      guard_cnt_r <= 4'd0;
    end else if ((state_r == ST_XFER) && (state_s == ST_GUARD)) begin
      guard_cnt_r <= GUARD_LOAD;
    end else if ((state_r == ST_GUARD) && (guard_cnt_r != 4'd0)) begin
      guard_cnt_r <= guard_cnt_r - 4'd1;
    end else begin
      guard_cnt_r <= guard_cnt_r;
    end
  end

  // Registered status outputs, each aligned with the state it describes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_en_r   <= 3'b000;
      busy_r    <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      tx_en_r   <= ((state_r == ST_IDLE) && any_req_s) ? onehot3(winner_s) : 3'b000;
      busy_r    <= (state_s != ST_IDLE);
      tmo_err_r <= tmo_hit_s;
    end
  end

  assign src_tx_en = tx_en_r;
  assign busy      = busy_r;
  assign tmo_err   = tmo_err_r;
  assign grant_id  = grant_id_r;

endmodule
